// File: rtl/multicycle_alu_pkg.sv
// Shared opcodes, flag indices and FSM encoding for multicycle_alu.
// Also consumed by alu_comb_core.
package multicycle_alu_pkg;

  localparam logic [4:0] OP_A    = 5'h00;
  localparam logic [4:0] OP_B    = 5'h01;
  localparam logic [4:0] OP_NOTA = 5'h02;
  localparam logic [4:0] OP_NOTB = 5'h03;
  localparam logic [4:0] OP_ADD  = 5'h04;
  localparam logic [4:0] OP_ADC  = 5'h05;
  localparam logic [4:0] OP_SUB  = 5'h06;
  localparam logic [4:0] OP_AND  = 5'h07;
  localparam logic [4:0] OP_OR   = 5'h08;
  localparam logic [4:0] OP_XOR  = 5'h09;
  localparam logic [4:0] OP_NAND = 5'h0A;
  localparam logic [4:0] OP_LSL1 = 5'h0B;
  localparam logic [4:0] OP_LSR1 = 5'h0C;
  localparam logic [4:0] OP_ASR1 = 5'h0D;
  localparam logic [4:0] OP_CSL1 = 5'h0E;
  localparam logic [4:0] OP_CSR1 = 5'h0F;
  localparam logic [4:0] OP_MUL  = 5'h10;
  localparam logic [4:0] OP_MULH = 5'h11;
  localparam logic [4:0] OP_SHLN = 5'h12;
  localparam logic [4:0] OP_SHRN = 5'h13;
  localparam logic [4:0] OP_ASRN = 5'h14;
  localparam logic [4:0] OP_ROLN = 5'h15;
  localparam logic [4:0] OP_DIVU = 5'h16;
  localparam logic [4:0] OP_REMU = 5'h17;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/alu_comb_core.sv
// Combinational 16-function single-cycle ALU with carry/overflow
// generation and per-op flag write qualifiers.
module alu_comb_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             cin,
  output logic [WIDTH-1:0] r,
  output logic             c,
  output logic             o,
  output logic             c_wr,
  output logic             o_wr
);
  import multicycle_alu_pkg::*;

  localparam int M = WIDTH - 1;

  logic [WIDTH:0] sum;

  always_comb begin
    r    = '0;
    c    = 1'b0;
    o    = 1'b0;
    c_wr = 1'b0;
    o_wr = 1'b0;
    sum  = '0;
    unique case ({1'b0, op})
      OP_A:    r = a;
      OP_B:    r = b;
      OP_NOTA: r = ~a;
      OP_NOTB: r = ~b;
      OP_ADD, OP_ADC: begin
        sum = {1'b0, a} + {1'b0, b};
        if (op == OP_ADC[3:0])
          sum = sum + {{WIDTH{1'b0}}, cin};
        r    = sum[M:0];
        c    = sum[WIDTH];
        o    = (a[M] == b[M]) && (r[M] != a[M]);
        c_wr = 1'b1;
        o_wr = 1'b1;
      end
      OP_SUB: begin
        sum  = {1'b0, a} - {1'b0, b};
        r    = sum[M:0];
        c    = sum[WIDTH];
        o    = (a[M] != b[M]) && (r[M] == b[M]);
        c_wr = 1'b1;
        o_wr = 1'b1;
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_LSL1: begin
        r = {a[M-1:0], 1'b0};
        c = a[M];
        c_wr = 1'b1;
      end
      OP_LSR1: begin
        r = {1'b0, a[M:1]};
        c = a[0];
        c_wr = 1'b1;
      end
      OP_ASR1: begin
        r = {a[M], a[M:1]};
        c = a[0];
        c_wr = 1'b1;
      end
      OP_CSL1: begin
        r = {a[M-1:0], a[M]};
        c = a[M];
        c_wr = 1'b1;
      end
      OP_CSR1: begin
        r = {a[0], a[M:1]};
        c = a[0];
        c_wr = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU with valid/ready handshake and iterative MUL/shift-by-N.
// Define MULTICYCLE_ALU_DIV_EN to add restoring DIVU/REMU.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       FunSel,
  input  logic             WF,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUOut,
  output logic [3:0]       FlagsOut,
  output logic             Busy
);
  import multicycle_alu_pkg::*;

  localparam int SHW = $clog2(WIDTH);
  localparam int M   = WIDTH - 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] r_q, a_q, w_hi, w_lo;
  logic [WIDTH-1:0] hi_n, lo_n, res_n;
  logic [4:0]       op_q;
  logic             wf_q, c_n;
  logic [SHW-1:0]   cnt, n;
  logic [3:0]       flags_q;
  logic [WIDTH:0]   sum;
  logic             is_mul, is_sh;
  logic [WIDTH-1:0] cr;
  logic             cc, co, cc_wr, co_wr;
`ifdef MULTICYCLE_ALU_DIV_EN
  logic [WIDTH-1:0] b_q, dif;
  logic [WIDTH:0]   sh;
  logic             is_div;
  assign is_div = (FunSel == OP_DIVU) || (FunSel == OP_REMU);
`endif

  assign InReady  = (state == IDLE);
  assign OutValid = (state == DONE);
  assign Busy     = (state == RUN);
  assign ALUOut   = r_q;
  assign FlagsOut = flags_q;
  assign n        = B[SHW-1:0];
  assign is_mul   = (FunSel == OP_MUL) || (FunSel == OP_MULH);
  assign is_sh    = (FunSel >= OP_SHLN) && (FunSel <= OP_ROLN);

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .a    (A),
    .b    (B),
    .op   (FunSel[3:0]),
    .cin  (flags_q[FLAG_C]),
    .r    (cr),
    .c    (cc),
    .o    (co),
    .c_wr (cc_wr),
    .o_wr (co_wr)
  );

  // One iteration of the running multi-cycle op
  always_comb begin
    hi_n  = w_hi;
    lo_n  = w_lo;
    c_n   = 1'b0;
    res_n = '0;
    sum   = '0;
`ifdef MULTICYCLE_ALU_DIV_EN
    sh  = '0;
    dif = '0;
`endif
    unique case (op_q)
      OP_MUL, OP_MULH: begin
        sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, a_q} : '0);
        hi_n  = sum[WIDTH:1];
        lo_n  = {sum[0], w_lo[M:1]};
        c_n   = |hi_n;
        res_n = (op_q == OP_MUL) ? lo_n : hi_n;
      end
      OP_SHLN: begin
        c_n   = w_lo[M];
        lo_n  = {w_lo[M-1:0], 1'b0};
        res_n = lo_n;
      end
      OP_SHRN: begin
        c_n   = w_lo[0];
        lo_n  = {1'b0, w_lo[M:1]};
        res_n = lo_n;
      end
      OP_ASRN: begin
        c_n   = w_lo[0];
        lo_n  = {w_lo[M], w_lo[M:1]};
        res_n = lo_n;
      end
      OP_ROLN: begin
        c_n   = w_lo[M];
        lo_n  = {w_lo[M-1:0], w_lo[M]};
        res_n = lo_n;
      end
`ifdef MULTICYCLE_ALU_DIV_EN
      OP_DIVU, OP_REMU: begin
        sh = {w_hi, w_lo[M]};
        if (sh >= {1'b0, b_q}) begin
          dif  = sh[M:0] - b_q;
          hi_n = dif;
          lo_n = {w_lo[M-1:0], 1'b1};
        end else begin
          hi_n = sh[M:0];
          lo_n = {w_lo[M-1:0], 1'b0};
        end
        c_n   = ~|b_q;
        res_n = (op_q == OP_DIVU) ? lo_n : hi_n;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      r_q     <= '0;
      flags_q <= '0;
      a_q     <= '0;
      w_hi    <= '0;
      w_lo    <= '0;
      op_q    <= '0;
      wf_q    <= 1'b0;
      cnt     <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
      b_q     <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: if (InValid) begin
          a_q  <= A;
          op_q <= FunSel;
          wf_q <= WF;
`ifdef MULTICYCLE_ALU_DIV_EN
          b_q  <= B;
`endif
          unique case (1'b1)
            !FunSel[4]: begin
              r_q   <= cr;
              state <= DONE;
              if (WF) begin
                flags_q[FLAG_Z] <= ~|cr;
                flags_q[FLAG_N] <= cr[M];
                if (cc_wr) flags_q[FLAG_C] <= cc;
                if (co_wr) flags_q[FLAG_O] <= co;
              end
            end
            is_mul: begin
              w_hi  <= '0;
              w_lo  <= B;
              cnt   <= SHW'(WIDTH - 1);
              state <= RUN;
            end
            is_sh: begin
              if (n == '0) begin
                r_q   <= A;
                state <= DONE;
                if (WF) begin
                  flags_q[FLAG_Z] <= ~|A;
                  flags_q[FLAG_N] <= A[M];
                end
              end else begin
                w_lo  <= A;
                cnt   <= n - SHW'(1);
                state <= RUN;
              end
            end
`ifdef MULTICYCLE_ALU_DIV_EN
            is_div: begin
              w_hi  <= '0;
              w_lo  <= A;
              cnt   <= SHW'(WIDTH - 1);
              state <= RUN;
            end
`endif
            default: begin
              r_q   <= '0;
              state <= DONE;
            end
          endcase
        end
        RUN: begin
          w_hi <= hi_n;
          w_lo <= lo_n;
          cnt  <= cnt - SHW'(1);
          if (cnt == '0) begin
            r_q   <= res_n;
            state <= DONE;
            if (wf_q) begin
              flags_q[FLAG_Z] <= ~|res_n;
              flags_q[FLAG_N] <= res_n[M];
              flags_q[FLAG_C] <= c_n;
            end
          end
        end
        DONE: if (OutReady) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
Parametrised successor of the datapath ALU. It supports any data width, registers its result, and uses a valid/ready handshake on both input and output. It keeps the 16 single-cycle functions and adds iterative multi-cycle operations: multiply and shift-by-N. It sits between the register-file read ports and the writeback mux, and the control unit stalls on InReady/OutValid.

Parameters:
WIDTH, 32, datapath width in bits (min 4).
SHW, $clog2(WIDTH), derived localparam: shift-amount width; not overridable.

Ports:
Clock  in  1  single system clock, rising edge.
Reset  in  1  asynchronous, active-low reset.
InValid  in  1  operation request.
InReady  out  1  block can accept; high only in IDLE.
A  in  WIDTH  operand A.
B  in  WIDTH  operand B; for shift-by-N ops, B[SHW-1:0] is the shift amount.
FunSel  in  5  operation code.
WF  in  1  write-flags enable for this operation; captured at accept.
OutValid  out  1  result available.
OutReady  in  1  consumer takes the result.
ALUOut  out  WIDTH  registered result.
FlagsOut  out  4  {Z,C,N,O}, registered.
Busy  out  1  high in RUN.

Behaviour:
- Accept when InValid&&InReady. A, B, FunSel and WF are latched. The carry-in is sampled from FlagsOut[2] at accept.
- FSM states: IDLE -> (accept) -> RUN or DONE; RUN -> DONE when the counter expires; DONE -> IDLE on OutReady. OutValid=1 only in DONE. ALUOut and FlagsOut hold stable in DONE until the handshake.
- Single-cycle ops 0x00–0x0F: A, B, ~A, ~B, ADD, ADC, SUB, AND, OR, XOR, NAND, LSL1, LSR1, ASR1, CSL1, CSR1. They go IDLE->DONE, so OutValid rises on the first edge after accept (latency 1).
- 0x10 MUL: low WIDTH bits of the unsigned product, shift-add, one bit per cycle. WIDTH cycles in RUN, so latency WIDTH+1.
- 0x11 MULH: high WIDTH bits of the same product, same latency.
- 0x12 SHLN, 0x13 SHRN, 0x14 ASRN, 0x15 ROLN: shift/rotate A by n=B[SHW-1:0], one bit per cycle, latency n+1. If n==0: go directly to DONE with ALUOut=A, latency 1.
- FunSel 0x16–0x1F is illegal: ALUOut=0, flags never updated, latency 1, OutValid still asserted.
- Arithmetic uses a WIDTH+1-bit internal sum. ADD/ADC: C=carry out. SUB: C=borrow (1 iff A<B unsigned).
- O is signed overflow:
  - ADD/ADC: sign(A)==sign(B) && sign(R)!=sign(A).
  - SUB: sign(A)!=sign(B) && sign(R)==sign(B).
- Flags written only if the latched WF=1, on the same edge ALUOut is loaded:
  - Z: all legal ops; Z=(R==0).
  - N: all legal ops; N=R[WIDTH-1].
  - C: ADD, ADC, SUB, all shifts/rotates (C=last bit shifted out; unchanged if n==0), MUL/MULH (C=1 iff the high half is nonzero).
  - O: ADD, ADC, SUB only.
- Any flag not written retains its value.
- Reset asserted, including mid-RUN, aborts the operation. On reset: state=IDLE, ALUOut=0, FlagsOut=4'b0000, OutValid=0, Busy=0, InReady=1 after deassertion.
- InValid while not InReady is ignored; the requester must hold it.
- Back-to-back: DONE->IDLE on OutReady. InReady rises in the next cycle, so there is no accept on the same edge as result consumption.

Optional Feature:
Macro MULTICYCLE_ALU_DIV_EN.
- Defined: 0x16 DIVU (quotient) and 0x17 REMU (remainder) are legal. They use restoring division, WIDTH RUN cycles, latency WIDTH+1. Flags Z, N per result, C=1 on divide-by-zero.
- Divide by zero: quotient all-ones, remainder=A, latency still WIDTH+1.
- Undefined: 0x16/0x17 are illegal ops as above; no divider logic is synthesised.

Decomposition:
Shared package multicycle_alu_pkg holds:
- FunSel opcode localparams (OP_ADD … OP_ROLN, OP_DIVU, OP_REMU).
- Flag bit indices (FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_O=0).
- FSM state encoding (IDLE, RUN, DONE).

One sub-module, alu_comb_core: the purely combinational 16-op single-cycle function plus the C/O generation. It is reused unchanged by the top FSM and counter logic.

Test Plan:
- WIDTH=32, WF=1: ADD A=0x7FFFFFFF, B=1 -> ALUOut=0x80000000, Flags Z0 C0 N1 O1, OutValid one cycle after accept.
- SUB A=3, B=5 -> 0xFFFFFFFE, C=1 (borrow), N=1, O=0. Then ADC A=1, B=1 -> ALUOut=3 (uses C=1).
- MUL A=0x00010000, B=0x00010000 -> ALUOut=0, C=1, Z=1, OutValid exactly 33 cycles after accept. MULH with the same operands -> 0x00000001.
- ASRN A=0x80000000, B=4 -> 0xF8000000 after 5 cycles. SHLN with n=0 -> ALUOut=A, latency 1, C unchanged.
- Hold OutReady=0 for 10 cycles in DONE -> ALUOut/FlagsOut stable, InReady=0. Assert Reset at RUN cycle 7 of MUL -> all outputs 0, IDLE, next op executes normally.
- WIDTH=8 build, illegal FunSel 0x1F with WF=1 -> ALUOut=0x00, flags unchanged. With MULTICYCLE_ALU_DIV_EN: DIVU 200/0 -> 0xFF, C=1, latency 9.
